// File: rtl/obuf_ser_tx.sv
// ---------------------------------------------------------------------------
// obuf_ser_tx
//   Parallel-to-serial transmit driver for one tristate pad (OBUFT I/T pair).
//   Words arrive over a valid/ready handshake and are shifted onto a single
//   pin, one bit every CLK_DIV clocks. After the last bit the pin is driven
//   at IDLE_LEVEL for TURNAROUND clocks, then released (Hi-Z).
//
// Ports
//   mclk       : system clock, rising edge
//   mrst_n     : asynchronous reset, active low
//   din        : word to transmit (WIDTH bits)
//   din_valid  : din holds a valid word
//   din_ready  : block accepts din this cycle
//   busy       : high whenever the FSM is not IDLE
//   dq         : serial data to pad buffer I (registered)
//   dq_t       : tristate control to pad buffer T, 1 = Hi-Z (registered)
//   state_dbg  : current FSM state (debug visibility)
//
// Handshake: a word is transferred in every cycle where din_valid and
// din_ready are both high. din_ready is decoded from registered state and
// counters only, so it never depends on din_valid. A producer may raise or
// drop din_valid freely while din_ready is low; nothing is consumed then.
// ---------------------------------------------------------------------------
module obuf_ser_tx #(
  parameter int   WIDTH      = 8,
  parameter int   CLK_DIV    = 2,
  parameter int   LSB_FIRST  = 0,
  parameter logic IDLE_LEVEL = 1'b1,
  parameter int   TURNAROUND = 1
) (
  input  logic             mclk,
  input  logic             mrst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             busy,
  output logic             dq,
  output logic             dq_t,
  output logic [1:0]       state_dbg
);

  localparam int BIT_W = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
  localparam int DIV_W = ($clog2(CLK_DIV + 1) < 1) ? 1 : $clog2(CLK_DIV + 1);
  localparam int TA_W  = ($clog2(TURNAROUND + 1) < 1) ? 1 : $clog2(TURNAROUND + 1);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TA_W-1:0]  TA_LAST  = TA_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TAIL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [TA_W-1:0]  tail_cnt_q, tail_cnt_d;
  logic             dq_q, dq_d;
  logic             dq_t_q, dq_t_d;

  logic             word_end;
  logic             xfer;
  logic [WIDTH-1:0] shifted;

  // The bit that goes on the pin first for a given register image.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
  endfunction

  // Move the next bit into the "first bit" position.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  // Final cycle of the final bit: the only SHIFT cycle that can take a new
  // word, which lets back-to-back words stream with no gap.
  assign word_end  = (state_q == ST_SHIFT) && (bit_cnt_q == '0) && (div_cnt_q == '0);
  assign din_ready = (state_q == ST_IDLE) || word_end;
  assign busy      = (state_q != ST_IDLE);
  assign xfer      = din_valid & din_ready;
  assign dq        = dq_q;
  assign dq_t      = dq_t_q;
  assign state_dbg = state_q;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    tail_cnt_d = tail_cnt_q;
    dq_d       = dq_q;
    dq_t_d     = dq_t_q;
    shifted    = shift_word(shreg_q);

    case (state_q)
      ST_IDLE: begin
        dq_d   = IDLE_LEVEL;
        dq_t_d = 1'b1;
        if (xfer) begin
          state_d   = ST_SHIFT;
          shreg_d   = din;
          bit_cnt_d = BIT_LAST;
          div_cnt_d = DIV_LAST;
          dq_d      = first_bit(din);
          dq_t_d    = 1'b0;
        end
      end

      ST_SHIFT: begin
        if (div_cnt_q != '0) begin
          div_cnt_d = div_cnt_q - DIV_W'(1);
        end else if (bit_cnt_q != '0) begin
          shreg_d   = shifted;
          dq_d      = first_bit(shifted);
          bit_cnt_d = bit_cnt_q - BIT_W'(1);
          div_cnt_d = DIV_LAST;
        end else if (xfer) begin
          // Reload for a gapless follow-on word; pin stays driven.
          shreg_d   = din;
          bit_cnt_d = BIT_LAST;
          div_cnt_d = DIV_LAST;
          dq_d      = first_bit(din);
          dq_t_d    = 1'b0;
        end else if (TURNAROUND > 0) begin
          state_d    = ST_TAIL;
          tail_cnt_d = TA_LAST;
          dq_d       = IDLE_LEVEL;
          dq_t_d     = 1'b0;
        end else begin
          state_d = ST_IDLE;
          dq_d    = IDLE_LEVEL;
          dq_t_d  = 1'b1;
        end
      end

      ST_TAIL: begin
        dq_d   = IDLE_LEVEL;
        dq_t_d = 1'b0;
        if (tail_cnt_q == '0) begin
          state_d = ST_IDLE;
          dq_t_d  = 1'b1;
        end else begin
          tail_cnt_d = tail_cnt_q - TA_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        dq_d    = IDLE_LEVEL;
        dq_t_d  = 1'b1;
      end
    endcase
  end

  // Reset releases the pin immediately, abandoning any bit in progress.
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      tail_cnt_q <= '0;
      dq_q       <= IDLE_LEVEL;
      dq_t_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      tail_cnt_q <= tail_cnt_d;
      dq_q       <= dq_d;
      dq_t_q     <= dq_t_d;
    end
  end

endmodule
